// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and the
// timer register map used by the bridge, its bench and other masters.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_ADDR_W  = 32;
   localparam int APB_DATA_W  = 32;
   localparam int APB_TIMEOUT = 16;
   localparam int APB_CNT_W   = 8;

   // Timer register slave map (byte addresses)
   localparam logic [31:0] TMR_CTRL_ADDR     = 32'h00;
   localparam logic [31:0] TMR_STATUS_ADDR   = 32'h04;
   localparam logic [31:0] TMR_LOAD_ADDR     = 32'h08;
   localparam logic [31:0] TMR_COUNT_ADDR    = 32'h0C;
   localparam logic [31:0] TMR_PRESCALE_ADDR = 32'h10;
   localparam logic [31:0] TMR_CMP_ADDR      = 32'h14;
   localparam logic [31:0] TMR_IRQ_EN_ADDR   = 32'h18;
   localparam logic [31:0] TMR_IRQ_STAT_ADDR = 32'h1C;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the ACCESS phase; flags when the last allowed
// cycle without pready has been reached.
module apb_timeout_cnt #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic reached_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next count: clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // count register
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign reached_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns a single-beat valid/ready command into one
// SETUP/ACCESS transfer and returns a one-cycle response pulse carrying
// read data, slave error and a local timeout flag.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = APB_TIMEOUT,
   parameter int CNT_W   = APB_CNT_W
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                busy,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   input  logic                pready,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pslverr
);

   apb_state_e          state_q;
   logic                psel_q, penable_q, pwrite_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic [DATA_W/8-1:0] pstrb_q;
   logic                rsp_valid_q, rsp_err_q, rsp_timeout_q;
   logic [DATA_W-1:0]   rsp_rdata_q;

   logic in_access, accept, to_reached;

   assign in_access = (state_q == ST_ACCESS);
   // A new command may be taken while the current one completes, giving
   // back-to-back transfers every two cycles.
   assign cmd_ready = (state_q == ST_IDLE) | (in_access & pready & ~sys_rst);
   assign accept    = cmd_valid & cmd_ready;

   apb_timeout_cnt #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_to_cnt (
      .clk_i     (sys_clk),
      .rst_i     (sys_rst),
      .clr_i     (state_q == ST_SETUP),
      .en_i      (in_access & ~pready & ~to_reached),
      .reached_o (to_reached)
   );

   // transfer FSM with registered APB and response outputs
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         // response is a single-cycle pulse; payload is zero otherwise
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;

         if (accept) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
            pstrb_q  <= cmd_write ? cmd_strb  : '0;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_SETUP;
                  psel_q  <= 1'b1;
               end
            end
            ST_SETUP: begin
               state_q   <= ST_ACCESS;
               penable_q <= 1'b1;
            end
            ST_ACCESS: begin
               // pready takes priority over the timeout on the last cycle
               if (pready) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= pslverr;
                  rsp_rdata_q <= pwrite_q ? '0 : prdata;
                  penable_q   <= 1'b0;
                  if (accept) begin
                     state_q <= ST_SETUP;
                  end else begin
                     state_q <= ST_IDLE;
                     psel_q  <= 1'b0;
                  end
               end else if (to_reached) begin
                  state_q       <= ST_IDLE;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB completer model
// (8-word memory, configurable wait states, error and stall modes).
module tb_apb_master_bridge;
   import apb_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_err, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0]  pstrb;

   int vec  = 0;
   int miss = 0;

   // completer model controls
   int   wait_states = 0;
   logic pready_tie  = 1'b0;
   logic hold_low    = 1'b0;
   logic err_mode    = 1'b0;
   int   wcnt;
   logic [31:0] mem [8];

   always #5 sys_clk = ~sys_clk;

   apb_master_bridge dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
      .pslverr(pslverr)
   );

   assign pready  = hold_low ? 1'b0 :
                    (pready_tie ? 1'b1 : (psel && penable && wcnt == wait_states));
   assign pslverr = err_mode & pready & psel & penable;
   assign prdata  = mem[paddr[4:2]];

   always @(posedge sys_clk) begin
      if (!(psel && penable) || pready) wcnt <= 0;
      else                              wcnt <= wcnt + 1;
      if (psel && penable && pready && pwrite && !err_mode)
         for (int b = 0; b < 4; b++)
            if (pstrb[b]) mem[paddr[4:2]][8*b +: 8] <= pwdata[8*b +: 8];
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // present one command for one accepting edge (bridge must be IDLE)
   task automatic do_cmd(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      tick(); tick();
      vec++; if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
         miss++; $display("FAIL reset_apb: got %b/%b/%b %h %h %h want all 0", psel, penable, pwrite, paddr, pwdata, pstrb); end
      vec++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, busy} !== '0) begin
         miss++; $display("FAIL reset_rsp: got v%b e%b t%b d%h busy%b want all 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata, busy); end
      sys_rst = 1'b0;
      tick();
      vec++; if (cmd_ready !== 1'b1) begin
         miss++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_write_read();
      pready_tie = 1'b1; wait_states = 0;
      do_cmd(1'b1, TMR_COUNT_ADDR, 32'h1234_5678, 4'hF);
      vec++; if ({psel, penable, pwrite, busy} !== 4'b1011 || paddr !== 32'h0C || pwdata !== 32'h1234_5678 || pstrb !== 4'hF) begin
         miss++; $display("FAIL wr_setup: got sel%b en%b wr%b busy%b a%h d%h s%h want 1011 0c 12345678 f", psel, penable, pwrite, busy, paddr, pwdata, pstrb); end
      tick();
      vec++; if ({psel, penable, rsp_valid} !== 3'b110) begin
         miss++; $display("FAIL wr_access: got sel%b en%b rv%b want 110", psel, penable, rsp_valid); end
      tick();
      vec++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0 || psel !== 1'b0 || busy !== 1'b0) begin
         miss++; $display("FAIL wr_rsp: got v%b e%b t%b d%h sel%b busy%b want 100 0 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel, busy); end
      tick();
      vec++; if (rsp_valid !== 1'b0) begin
         miss++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
      do_cmd(1'b0, TMR_COUNT_ADDR, 32'h0, 4'h0);
      tick(); tick();
      vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
         miss++; $display("FAIL rd_back: got v%b d%h e%b want 1 12345678 0", rsp_valid, rsp_rdata, rsp_err); end
      pready_tie = 1'b0;
      tick();
   endtask

   task automatic test_wait_read();
      int n, g;
      wait_states = 0;
      do_cmd(1'b1, TMR_CTRL_ADDR, 32'h0000_0100, 4'hF);
      tick(); tick(); tick();
      sys_rst = 1'b1; tick(); sys_rst = 1'b0;
      wait_states = 2;
      do_cmd(1'b0, TMR_CTRL_ADDR, 32'hFFFF_FFFF, 4'hF);
      vec++; if (pwrite !== 1'b0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin
         miss++; $display("FAIL rdw_setup: got wr%b d%h s%h want 0 0 0", pwrite, pwdata, pstrb); end
      n = 0; g = 0;
      while (rsp_valid !== 1'b1 && g < 12) begin
         if (penable === 1'b1) begin
            n++;
            vec++; if (pwdata !== 32'h0 || pstrb !== 4'h0 || paddr !== 32'h0) begin
               miss++; $display("FAIL rdw_hold: got d%h s%h a%h want 0 0 0", pwdata, pstrb, paddr); end
         end
         tick(); g++;
      end
      vec++; if (n !== 3) begin
         miss++; $display("FAIL rdw_len: got %0d access cycles want 3", n); end
      vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h100 || rsp_err !== 1'b0) begin
         miss++; $display("FAIL rdw_rsp: got v%b d%h e%b want 1 100 0", rsp_valid, rsp_rdata, rsp_err); end
      tick();
   endtask

   task automatic test_slverr();
      wait_states = 0; err_mode = 1'b1;
      do_cmd(1'b1, TMR_CTRL_ADDR, 32'h0000_0900, 4'h2);
      vec++; if (pstrb !== 4'h2 || pwdata !== 32'h900) begin
         miss++; $display("FAIL err_setup: got s%h d%h want 2 900", pstrb, pwdata); end
      tick(); tick();
      vec++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || busy !== 1'b0 || psel !== 1'b0) begin
         miss++; $display("FAIL err_rsp: got v%b e%b t%b busy%b sel%b want 110 0 0", rsp_valid, rsp_err, rsp_timeout, busy, psel); end
      err_mode = 1'b0;
      tick();
      vec++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
         miss++; $display("FAIL err_clear: got e%b v%b want 0 0", rsp_err, rsp_valid); end
   endtask

   task automatic test_timeout();
      int n, g;
      hold_low = 1'b1;
      do_cmd(1'b0, TMR_PRESCALE_ADDR, 32'h0, 4'h0);
      n = 0; g = 0;
      while (rsp_valid !== 1'b1 && g < 40) begin
         if (penable === 1'b1) n++;
         tick(); g++;
      end
      vec++; if (n !== 16) begin
         miss++; $display("FAIL to_len: got %0d penable cycles want 16", n); end
      vec++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable, busy} !== 6'b111000 || rsp_rdata !== 32'h0) begin
         miss++; $display("FAIL to_rsp: got v%b e%b t%b sel%b en%b busy%b d%h want 111000 0", rsp_valid, rsp_err, rsp_timeout, psel, penable, busy, rsp_rdata); end
      hold_low = 1'b0; wait_states = 15;
      tick();
      do_cmd(1'b1, TMR_CMP_ADDR, 32'hA5A5_0001, 4'hF);
      n = 0; g = 0;
      while (rsp_valid !== 1'b1 && g < 40) begin
         if (penable === 1'b1) n++;
         tick(); g++;
      end
      vec++; if (n !== 16) begin
         miss++; $display("FAIL to_edge_len: got %0d penable cycles want 16", n); end
      vec++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin
         miss++; $display("FAIL to_edge_rsp: got v%b e%b t%b want 100", rsp_valid, rsp_err, rsp_timeout); end
      wait_states = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [4];
      logic [31:0] d [4];
      int rsps = 0;
      a[0] = TMR_PRESCALE_ADDR; a[1] = TMR_CMP_ADDR; a[2] = TMR_IRQ_EN_ADDR; a[3] = TMR_IRQ_STAT_ADDR;
      d[0] = 32'h1111_0000; d[1] = 32'h2222_0001; d[2] = 32'h3333_0002; d[3] = 32'h4444_0003;
      cmd_write = 1'b1; cmd_strb = 4'hF; cmd_addr = a[0]; cmd_wdata = d[0];
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid === 1'b1) rsps++;
         vec++; if ({psel, penable, cmd_ready} !== 3'b100 || paddr !== a[i] || pwdata !== d[i] || rsp_valid !== (i > 0)) begin
            miss++; $display("FAIL b2b_setup%0d: got sel%b en%b rdy%b a%h d%h rv%b", i, psel, penable, cmd_ready, paddr, pwdata, rsp_valid); end
         if (i < 3) begin cmd_addr = a[i+1]; cmd_wdata = d[i+1]; end
         else cmd_valid = 1'b0;
         tick();
         vec++; if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1110) begin
            miss++; $display("FAIL b2b_access%0d: got sel%b en%b rdy%b rv%b want 1110", i, psel, penable, cmd_ready, rsp_valid); end
      end
      tick();
      if (rsp_valid === 1'b1) rsps++;
      vec++; if (rsps !== 4 || psel !== 1'b0 || busy !== 1'b0) begin
         miss++; $display("FAIL b2b_done: got %0d rsps sel%b busy%b want 4 0 0", rsps, psel, busy); end
      tick();
      do_cmd(1'b0, TMR_IRQ_EN_ADDR, 32'h0, 4'h0);
      tick(); tick();
      vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3333_0002) begin
         miss++; $display("FAIL b2b_readback: got v%b d%h want 1 33330002", rsp_valid, rsp_rdata); end
      tick();
   endtask

   task automatic test_reset_mid();
      int n = 0;
      hold_low = 1'b1;
      do_cmd(1'b1, TMR_LOAD_ADDR, 32'hDEAD_BEEF, 4'hF);
      tick();
      vec++; if ({psel, penable} !== 2'b11) begin
         miss++; $display("FAIL rst_mid_pre: got sel%b en%b want 11", psel, penable); end
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0; hold_low = 1'b0;
      vec++; if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, busy} !== '0) begin
         miss++; $display("FAIL rst_mid_apb: got sel%b en%b wr%b a%h d%h s%h rv%b busy%b want all 0", psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, busy); end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (rsp_valid === 1'b1) n++;
      end
      vec++; if (n !== 0) begin
         miss++; $display("FAIL rst_mid_norsp: got %0d rsps want 0", n); end
      do_cmd(1'b0, TMR_COUNT_ADDR, 32'h0, 4'h0);
      tick(); tick();
      vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
         miss++; $display("FAIL rst_mid_after: got v%b d%h e%b want 1 12345678 0", rsp_valid, rsp_rdata, rsp_err); end
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wait_read();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
